// File: rtl/parking_pkg.sv
// Shared parking-controller definitions: gate FSM states, default lot
// capacity and occupancy bus width (also used by the counter and slot monitor).
package parking_pkg;

    localparam int OCC_WIDTH        = 8;
    localparam int DEFAULT_CAPACITY = 20;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_IN_OUTER  = 4'd1,
        ST_IN_BOTH   = 4'd2,
        ST_IN_INNER  = 4'd3,
        ST_OUT_INNER = 4'd4,
        ST_OUT_BOTH  = 4'd5,
        ST_OUT_OUTER = 4'd6,
        ST_REJECT    = 4'd7,
        ST_FAULT     = 4'd8
    } gate_state_t;

    // True for the states in which a car is actively traversing the gate
    // and the barrier must be raised.
    function automatic logic is_travel_state(input gate_state_t s);
        return (s == ST_IN_OUTER)  || (s == ST_IN_BOTH)  || (s == ST_IN_INNER) ||
               (s == ST_OUT_INNER) || (s == ST_OUT_BOTH) || (s == ST_OUT_OUTER);
    endfunction

endpackage

// File: rtl/sensor_debouncer.sv
// Two-flop synchronizer followed by a stability counter. The debounced
// output only follows the synced input after it has disagreed for
// DEBOUNCE_CYCLES consecutive cycles; shorter glitches are dropped.
module sensor_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic debounced
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          deb_reg;
    logic          deb_next;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    // Bring the asynchronous beam input into the clock domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Count consecutive mismatches; flip once the mismatch has persisted long enough.
    always_comb begin
        deb_next = deb_reg;
        cnt_next = '0;
        if (sync2_reg != deb_reg) begin
            if (cnt_reg == CNT_LAST) begin
                deb_next = sync2_reg;
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_reg <= 1'b0;
            cnt_reg <= '0;
        end else begin
            deb_reg <= deb_next;
            cnt_reg <= cnt_next;
        end
    end

    assign debounced = deb_reg;

endmodule

// File: rtl/parking_gate_sequencer.sv
// Parking gate sequencer: turns the outer/inner beam sensors into single
// car_in / car_out pulses, raises the barrier during a traversal, refuses
// entry when the lot is full and flags a fault on illegal or stalled sequences.
module parking_gate_sequencer
    import parking_pkg::*;
#(
    parameter int CAPACITY        = DEFAULT_CAPACITY,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sensor_outer,
    input  logic                 sensor_inner,
    input  logic [OCC_WIDTH-1:0] occupancy,
    output logic                 car_in,
    output logic                 car_out,
    output logic                 gate_open,
    output logic                 full,
    output logic                 fault
);

    // One extra bit so any CAPACITY up to 2^OCC_WIDTH compares correctly.
    localparam logic [OCC_WIDTH:0] CAP_W      = (OCC_WIDTH + 1)'(CAPACITY);
    localparam int                 DW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0]      DWELL_LAST = DW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    sensor_raw;
    logic [1:0]    sensor_deb;
    logic          deb_outer;
    logic          deb_inner;
    logic [1:0]    beams;          // {outer, inner}

    gate_state_t   state_reg;
    gate_state_t   state_next;
    logic [DW-1:0] dwell_reg;
    logic          timeout_hit;

    logic          full_reg;
    logic          car_in_reg,    car_in_next;
    logic          car_out_reg,   car_out_next;
    logic          gate_open_reg, gate_open_next;
    logic          fault_reg,     fault_next;

    assign sensor_raw = {sensor_inner, sensor_outer};

    // Identical conditioning path for each beam (index 0 = outer, 1 = inner).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_deb
            sensor_debouncer #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_deb (
                .clk       (clk),
                .reset     (reset),
                .raw       (sensor_raw[gi]),
                .debounced (sensor_deb[gi])
            );
        end
    endgenerate

    assign deb_outer = sensor_deb[0];
    assign deb_inner = sensor_deb[1];
    assign beams     = {deb_outer, deb_inner};

    // Lot-full flag, sampled once per cycle from the counter's occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_reg <= 1'b0;
        end else begin
            full_reg <= ({1'b0, occupancy} >= CAP_W);
        end
    end

    // Dwell counter: restarts on every state change and saturates so it never wraps in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            dwell_reg <= '0;
        end else if (state_next != state_reg) begin
            dwell_reg <= '0;
        end else if (dwell_reg < DWELL_LAST) begin
            dwell_reg <= dwell_reg + DW'(1);
        end
    end

    // A state is abandoned once it has been held for TIMEOUT_CYCLES cycles.
    assign timeout_hit = (state_reg != ST_IDLE) && (state_reg != ST_FAULT) &&
                         (dwell_reg == DWELL_LAST);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; beams encoding: 2'b10 outer only, 2'b01 inner only.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                case (beams)
                    2'b10:   state_next = full_reg ? ST_REJECT : ST_IN_OUTER;
                    2'b01:   state_next = ST_OUT_INNER;
                    2'b11:   state_next = ST_FAULT;
                    default: state_next = ST_IDLE;
                endcase
            end
            ST_IN_OUTER: begin
                case (beams)
                    2'b11:   state_next = ST_IN_BOTH;
                    2'b00:   state_next = ST_IDLE;
                    2'b01:   state_next = ST_FAULT;
                    default: state_next = ST_IN_OUTER;
                endcase
            end
            ST_IN_BOTH: begin
                case (beams)
                    2'b01:   state_next = ST_IN_INNER;
                    2'b10:   state_next = ST_IN_OUTER;
                    2'b00:   state_next = ST_FAULT;
                    default: state_next = ST_IN_BOTH;
                endcase
            end
            ST_IN_INNER: begin
                case (beams)
                    2'b00:   state_next = ST_IDLE;
                    2'b11:   state_next = ST_IN_BOTH;
                    2'b10:   state_next = ST_FAULT;
                    default: state_next = ST_IN_INNER;
                endcase
            end
            ST_OUT_INNER: begin
                case (beams)
                    2'b11:   state_next = ST_OUT_BOTH;
                    2'b00:   state_next = ST_IDLE;
                    2'b10:   state_next = ST_FAULT;
                    default: state_next = ST_OUT_INNER;
                endcase
            end
            ST_OUT_BOTH: begin
                case (beams)
                    2'b10:   state_next = ST_OUT_OUTER;
                    2'b01:   state_next = ST_OUT_INNER;
                    2'b00:   state_next = ST_FAULT;
                    default: state_next = ST_OUT_BOTH;
                endcase
            end
            ST_OUT_OUTER: begin
                case (beams)
                    2'b00:   state_next = ST_IDLE;
                    2'b11:   state_next = ST_OUT_BOTH;
                    2'b01:   state_next = ST_FAULT;
                    default: state_next = ST_OUT_OUTER;
                endcase
            end
            ST_REJECT: begin
                if (beams == 2'b00) state_next = ST_IDLE;
            end
            ST_FAULT: begin
                if (beams == 2'b00) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        // A stalled sequence overrides any sensor-driven move.
        if (timeout_hit) state_next = ST_FAULT;
    end

    // Output decode from the transition being taken, so outputs line up with the new state.
    always_comb begin
        car_in_next    = (state_reg == ST_IN_INNER)  && (state_next == ST_IDLE);
        car_out_next   = (state_reg == ST_OUT_OUTER) && (state_next == ST_IDLE);
        gate_open_next = is_travel_state(state_next);
        fault_next     = (state_next == ST_FAULT);
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            car_in_reg    <= 1'b0;
            car_out_reg   <= 1'b0;
            gate_open_reg <= 1'b0;
            fault_reg     <= 1'b0;
        end else begin
            car_in_reg    <= car_in_next;
            car_out_reg   <= car_out_next;
            gate_open_reg <= gate_open_next;
            fault_reg     <= fault_next;
        end
    end

    assign car_in    = car_in_reg;
    assign car_out   = car_out_reg;
    assign gate_open = gate_open_reg;
    assign full      = full_reg;
    assign fault     = fault_reg;

endmodule
